// File: rtl/coreaxi_arb_pkg.sv
// Shared types for the multi-core AXI arbiter.
// FSM state encodings and index-width helper.
package coreaxi_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_XFER,
    WR_RESP
  } wr_state_t;

  localparam int AXI_AW = 64;
  localparam int AXI_DW = 64;
  localparam int AXI_SW = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coreaxi_arb_rr_pick.sv
// Combinational rotating-priority picker.
// Searches req from ptr upward, wrapping modulo n.
import coreaxi_arb_pkg::*;

module rr_pick #(
  parameter int n  = 2,
  parameter int iw = idx_w(n)
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] ptr,
  output logic [n-1:0]  gnt,
  output logic [iw-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < n; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = iw'(j);
      end
    end
  end

endmodule

// File: rtl/coreaxi_arb.sv
// Shares one AXI4 master among ncore upstream masters.
// Read and write channels arbitrate independently, one outstanding each.
import coreaxi_arb_pkg::*;

module coreaxi_arb #(
  parameter int ncore = 2,
  parameter int rr    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ncore-1:0][63:0]  s_axi_awaddr,
  input  logic [ncore-1:0][7:0]   s_axi_awlen,
  input  logic [ncore-1:0][2:0]   s_axi_awsize,
  input  logic [ncore-1:0][1:0]   s_axi_awburst,
  input  logic [ncore-1:0]        s_axi_awvalid,
  output logic [ncore-1:0]        s_axi_awready,
  input  logic [ncore-1:0][63:0]  s_axi_wdata,
  input  logic [ncore-1:0][7:0]   s_axi_wstrb,
  input  logic [ncore-1:0]        s_axi_wlast,
  input  logic [ncore-1:0]        s_axi_wvalid,
  output logic [ncore-1:0]        s_axi_wready,
  output logic [ncore-1:0][1:0]   s_axi_bresp,
  output logic [ncore-1:0]        s_axi_bvalid,
  input  logic [ncore-1:0]        s_axi_bready,
  input  logic [ncore-1:0][63:0]  s_axi_araddr,
  input  logic [ncore-1:0][7:0]   s_axi_arlen,
  input  logic [ncore-1:0][2:0]   s_axi_arsize,
  input  logic [ncore-1:0][1:0]   s_axi_arburst,
  input  logic [ncore-1:0]        s_axi_arvalid,
  output logic [ncore-1:0]        s_axi_arready,
  output logic [ncore-1:0][63:0]  s_axi_rdata,
  output logic [ncore-1:0][1:0]   s_axi_rresp,
  output logic [ncore-1:0]        s_axi_rlast,
  output logic [ncore-1:0]        s_axi_rvalid,
  input  logic [ncore-1:0]        s_axi_rready,
  output logic [63:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [63:0]             m_axi_wdata,
  output logic [7:0]              m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [63:0]             m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [63:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [ncore-1:0]        rd_grant,
  output logic [ncore-1:0]        wr_grant
);

  localparam int IW = idx_w(ncore);
  localparam logic [IW-1:0] LAST = IW'(ncore - 1);

  rd_state_t        rd_st_q, rd_st_d;
  wr_state_t        wr_st_q, wr_st_d;
  logic [ncore-1:0] rd_gnt_q, rd_gnt_d;
  logic [ncore-1:0] wr_gnt_q, wr_gnt_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [IW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic [ncore-1:0] rd_pick_gnt, wr_pick_gnt;
  logic [IW-1:0]    rd_pick_idx, wr_pick_idx;
  logic [IW-1:0]    rd_ptr_use, wr_ptr_use;
  logic [ncore-1:0] wr_req;

  logic rd_addr_ph, rd_data_ph;
  logic aw_ph, w_ph, b_ph;
  logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;

  // Fixed priority is a rotating search that always starts at 0.
  assign rd_ptr_use = (rr != 0) ? rd_ptr_q : '0;
  assign wr_ptr_use = (rr != 0) ? wr_ptr_q : '0;
  assign wr_req     = s_axi_awvalid | s_axi_wvalid;

  rr_pick #(.n(ncore), .iw(IW)) u_rd_pick (
    .req (s_axi_arvalid),
    .ptr (rd_ptr_use),
    .gnt (rd_pick_gnt),
    .idx (rd_pick_idx)
  );

  rr_pick #(.n(ncore), .iw(IW)) u_wr_pick (
    .req (wr_req),
    .ptr (wr_ptr_use),
    .gnt (wr_pick_gnt),
    .idx (wr_pick_idx)
  );

  assign rd_addr_ph = (rd_st_q == RD_ADDR);
  assign rd_data_ph = (rd_st_q == RD_DATA);
  assign aw_ph      = (wr_st_q == WR_XFER) && !aw_done_q;
  assign w_ph       = (wr_st_q == WR_XFER) && !w_done_q;
  assign b_ph       = (wr_st_q == WR_RESP);

  assign m_axi_araddr  = rd_addr_ph ? s_axi_araddr[rd_idx_q]  : '0;
  assign m_axi_arlen   = rd_addr_ph ? s_axi_arlen[rd_idx_q]   : '0;
  assign m_axi_arsize  = rd_addr_ph ? s_axi_arsize[rd_idx_q]  : '0;
  assign m_axi_arburst = rd_addr_ph ? s_axi_arburst[rd_idx_q] : '0;
  assign m_axi_arvalid = rd_addr_ph && s_axi_arvalid[rd_idx_q];
  assign m_axi_rready  = rd_data_ph && s_axi_rready[rd_idx_q];

  assign m_axi_awaddr  = aw_ph ? s_axi_awaddr[wr_idx_q]  : '0;
  assign m_axi_awlen   = aw_ph ? s_axi_awlen[wr_idx_q]   : '0;
  assign m_axi_awsize  = aw_ph ? s_axi_awsize[wr_idx_q]  : '0;
  assign m_axi_awburst = aw_ph ? s_axi_awburst[wr_idx_q] : '0;
  assign m_axi_awvalid = aw_ph && s_axi_awvalid[wr_idx_q];
  assign m_axi_wdata   = w_ph ? s_axi_wdata[wr_idx_q] : '0;
  assign m_axi_wstrb   = w_ph ? s_axi_wstrb[wr_idx_q] : '0;
  assign m_axi_wlast   = w_ph && s_axi_wlast[wr_idx_q];
  assign m_axi_wvalid  = w_ph && s_axi_wvalid[wr_idx_q];
  assign m_axi_bready  = b_ph && s_axi_bready[wr_idx_q];

  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_last_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast;
  assign b_hs      = m_axi_bvalid && m_axi_bready;

  assign rd_grant = rd_gnt_q;
  assign wr_grant = wr_gnt_q;

  always_comb begin
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    s_axi_rdata   = '0;
    s_axi_rresp   = '0;
    s_axi_rlast   = '0;
    for (int i = 0; i < ncore; i++) begin
      if (IW'(i) == rd_idx_q) begin
        if (rd_addr_ph) s_axi_arready[i] = m_axi_arready;
        if (rd_data_ph) begin
          s_axi_rvalid[i] = m_axi_rvalid;
          s_axi_rdata[i]  = m_axi_rdata;
          s_axi_rresp[i]  = m_axi_rresp;
          s_axi_rlast[i]  = m_axi_rlast;
        end
      end
    end
  end

  always_comb begin
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    s_axi_bresp   = '0;
    for (int i = 0; i < ncore; i++) begin
      if (IW'(i) == wr_idx_q) begin
        if (aw_ph) s_axi_awready[i] = m_axi_awready;
        if (w_ph)  s_axi_wready[i]  = m_axi_wready;
        if (b_ph) begin
          s_axi_bvalid[i] = m_axi_bvalid;
          s_axi_bresp[i]  = m_axi_bresp;
        end
      end
    end
  end

  always_comb begin
    rd_st_d  = rd_st_q;
    rd_gnt_d = rd_gnt_q;
    rd_idx_d = rd_idx_q;
    rd_ptr_d = rd_ptr_q;
    unique case (rd_st_q)
      RD_IDLE: begin
        if (|s_axi_arvalid) begin
          rd_st_d  = RD_ADDR;
          rd_gnt_d = rd_pick_gnt;
          rd_idx_d = rd_pick_idx;
          rd_ptr_d = (rd_pick_idx == LAST) ? '0 : rd_pick_idx + 1'b1;
        end
      end
      RD_ADDR: if (ar_hs) rd_st_d = RD_DATA;
      RD_DATA: begin
        if (r_last_hs) begin
          rd_st_d  = RD_IDLE;
          rd_gnt_d = '0;
        end
      end
      default: begin
        rd_st_d  = RD_IDLE;
        rd_gnt_d = '0;
      end
    endcase
  end

  // Flags count this cycle's handshakes so XFER exits without a bubble.
  always_comb begin
    wr_st_d   = wr_st_q;
    wr_gnt_d  = wr_gnt_q;
    wr_idx_d  = wr_idx_q;
    wr_ptr_d  = wr_ptr_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_last_hs;
    unique case (wr_st_q)
      WR_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (|wr_req) begin
          wr_st_d  = WR_XFER;
          wr_gnt_d = wr_pick_gnt;
          wr_idx_d = wr_pick_idx;
          wr_ptr_d = (wr_pick_idx == LAST) ? '0 : wr_pick_idx + 1'b1;
        end
      end
      WR_XFER: if (aw_done_d && w_done_d) wr_st_d = WR_RESP;
      WR_RESP: begin
        if (b_hs) begin
          wr_st_d   = WR_IDLE;
          wr_gnt_d  = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        wr_st_d  = WR_IDLE;
        wr_gnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st_q   <= RD_IDLE;
      wr_st_q   <= WR_IDLE;
      rd_gnt_q  <= '0;
      wr_gnt_q  <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rd_st_q   <= rd_st_d;
      wr_st_q   <= wr_st_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_coreaxi_arb.sv
// Directed self-checking bench for coreaxi_arb, ncore = 2.
// Downstream slave is driven by hand from each scenario task.
module tb_coreaxi_arb;

  logic clk;
  logic rst;
  logic [1:0][63:0] s_axi_awaddr;
  logic [1:0][7:0]  s_axi_awlen;
  logic [1:0][2:0]  s_axi_awsize;
  logic [1:0][1:0]  s_axi_awburst;
  logic [1:0]       s_axi_awvalid;
  logic [1:0]       s_axi_awready;
  logic [1:0][63:0] s_axi_wdata;
  logic [1:0][7:0]  s_axi_wstrb;
  logic [1:0]       s_axi_wlast;
  logic [1:0]       s_axi_wvalid;
  logic [1:0]       s_axi_wready;
  logic [1:0][1:0]  s_axi_bresp;
  logic [1:0]       s_axi_bvalid;
  logic [1:0]       s_axi_bready;
  logic [1:0][63:0] s_axi_araddr;
  logic [1:0][7:0]  s_axi_arlen;
  logic [1:0][2:0]  s_axi_arsize;
  logic [1:0][1:0]  s_axi_arburst;
  logic [1:0]       s_axi_arvalid;
  logic [1:0]       s_axi_arready;
  logic [1:0][63:0] s_axi_rdata;
  logic [1:0][1:0]  s_axi_rresp;
  logic [1:0]       s_axi_rlast;
  logic [1:0]       s_axi_rvalid;
  logic [1:0]       s_axi_rready;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [1:0]  rd_grant;
  logic [1:0]  wr_grant;

  int checks;
  int failures;
  int aw_hs_cnt;

  coreaxi_arb #(.ncore(2), .rr(1)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && m_axi_awvalid && m_axi_awready) aw_hs_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = '0;
    s_axi_wvalid = '0; s_axi_bready = '0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = '0; s_axi_rready = '0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bresp = '0; m_axi_bvalid = 0; m_axi_arready = 0;
    m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 0; m_axi_rvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (rd_grant !== 2'b00 || wr_grant !== 2'b00) begin
      failures++;
      $display("FAIL reset_grant got rd=%b wr=%b exp 00/00",
               rd_grant, wr_grant);
    end
    checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
         m_axi_rready, m_axi_bready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_m_valid got %b exp 0",
               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                m_axi_rready, m_axi_bready});
    end
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready,
         s_axi_rvalid, s_axi_bvalid} !== 10'b0) begin
      failures++;
      $display("FAIL reset_s_ready got %b exp 0",
               {s_axi_arready, s_axi_awready, s_axi_wready,
                s_axi_rvalid, s_axi_bvalid});
    end
  endtask

  task automatic test_single_read();
    logic [63:0] d;
    s_axi_araddr[1]  = 64'h8000_1000;
    s_axi_arlen[1]   = 8'd3;
    s_axi_arvalid[1] = 1'b1;
    s_axi_rready     = 2'b11;
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL sr_arb_latency got %b exp 0", m_axi_arvalid);
    end
    step();
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h8000_1000 ||
        m_axi_arlen !== 8'd3) begin
      failures++;
      $display("FAIL sr_ar_fwd got v=%b a=%h l=%0d exp 1/80001000/3",
               m_axi_arvalid, m_axi_araddr, m_axi_arlen);
    end
    checks++;
    if (rd_grant !== 2'b10) begin
      failures++;
      $display("FAIL sr_grant got %b exp 10", rd_grant);
    end
    m_axi_arready = 1'b1;
    #1;
    checks++;
    if (s_axi_arready !== 2'b10) begin
      failures++;
      $display("FAIL sr_arready got %b exp 10", s_axi_arready);
    end
    step();
    s_axi_arvalid = '0;
    m_axi_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      d = 64'hD000 + 64'(b);
      m_axi_rdata  = d;
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = (b == 3);
      #1;
      checks++;
      if (s_axi_rvalid !== 2'b10 || s_axi_rdata[1] !== d ||
          s_axi_rdata[0] !== 64'h0 || rd_grant !== 2'b10) begin
        failures++;
        $display("FAIL sr_beat%0d got v=%b d=%h g=%b exp 10/%h/10",
                 b, s_axi_rvalid, s_axi_rdata[1], rd_grant, d);
      end
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    #1;
    checks++;
    if (rd_grant !== 2'b00 || m_axi_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL sr_idle got g=%b exp 00", rd_grant);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  eg;
    logic [63:0] d;
    int          e;
    s_axi_araddr[0] = 64'h1000;
    s_axi_araddr[1] = 64'h2000;
    s_axi_arlen     = '{8'd1, 8'd1};
    s_axi_arvalid   = 2'b11;
    s_axi_rready    = 2'b11;
    for (int g = 0; g < 4; g++) begin
      e  = g % 2;
      eg = 2'b01 << e;
      step();
      m_axi_arready = 1'b1;
      #1;
      checks++;
      if (rd_grant !== eg ||
          m_axi_araddr !== (e == 0 ? 64'h1000 : 64'h2000)) begin
        failures++;
        $display("FAIL ct_grant%0d got g=%b a=%h exp %b",
                 g, rd_grant, m_axi_araddr, eg);
      end
      step();
      m_axi_arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
        d = 64'hC000 + 64'(g * 16 + b);
        m_axi_rdata  = d;
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = (b == 1);
        #1;
        checks++;
        if (s_axi_rvalid !== eg || s_axi_rdata[e] !== d ||
            s_axi_rdata[1-e] !== 64'h0) begin
          failures++;
          $display("FAIL ct_beat%0d_%0d got v=%b exp %b",
                   g, b, s_axi_rvalid, eg);
        end
        step();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
    end
    s_axi_arvalid = '0;
    #1;
    checks++;
    if (rd_grant !== 2'b00) begin
      failures++;
      $display("FAIL ct_idle got %b exp 00", rd_grant);
    end
  endtask

  task automatic test_write_w_first();
    int hs0;
    hs0 = aw_hs_cnt;
    s_axi_wdata[0]  = 64'hAAAA_0000;
    s_axi_wstrb[0]  = 8'hFF;
    s_axi_wlast[0]  = 1'b0;
    s_axi_wvalid[0] = 1'b1;
    m_axi_wready    = 1'b1;
    #1;
    checks++;
    if (s_axi_wready !== 2'b00 || wr_grant !== 2'b00) begin
      failures++;
      $display("FAIL ww_idle got r=%b g=%b exp 00/00",
               s_axi_wready, wr_grant);
    end
    step();
    checks++;
    if (wr_grant !== 2'b01 || m_axi_wvalid !== 1'b1 ||
        m_axi_wdata !== 64'hAAAA_0000 || s_axi_wready !== 2'b01 ||
        m_axi_awvalid !== 1'b0) begin
      failures++;
      $display("FAIL ww_beat0 got g=%b wv=%b wd=%h awv=%b",
               wr_grant, m_axi_wvalid, m_axi_wdata, m_axi_awvalid);
    end
    step();
    s_axi_wdata[0]   = 64'hAAAA_0001;
    s_axi_wlast[0]   = 1'b1;
    s_axi_awaddr[0]  = 64'h4000;
    s_axi_awlen[0]   = 8'd1;
    s_axi_awvalid[0] = 1'b1;
    #1;
    checks++;
    if (m_axi_wvalid !== 1'b1 || m_axi_wlast !== 1'b1 ||
        m_axi_wdata !== 64'hAAAA_0001 || m_axi_awvalid !== 1'b1 ||
        m_axi_awaddr !== 64'h4000 || s_axi_awready !== 2'b00) begin
      failures++;
      $display("FAIL ww_beat1 got wv=%b wl=%b awv=%b awa=%h",
               m_axi_wvalid, m_axi_wlast, m_axi_awvalid, m_axi_awaddr);
    end
    step();
    s_axi_wvalid = '0;
    s_axi_wlast  = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b0 ||
          s_axi_wready !== 2'b00) begin
        failures++;
        $display("FAIL ww_awwait%0d got awv=%b wv=%b wr=%b",
                 c, m_axi_awvalid, m_axi_wvalid, s_axi_wready);
      end
      step();
    end
    m_axi_awready = 1'b1;
    #1;
    checks++;
    if (s_axi_awready !== 2'b01) begin
      failures++;
      $display("FAIL ww_awready got %b exp 01", s_axi_awready);
    end
    step();
    s_axi_awvalid = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b1;
    m_axi_bresp   = 2'b00;
    s_axi_bready  = 2'b01;
    #1;
    checks++;
    if (s_axi_bvalid !== 2'b01 || m_axi_bready !== 1'b1 ||
        s_axi_bresp[0] !== 2'b00 || wr_grant !== 2'b01) begin
      failures++;
      $display("FAIL ww_resp got bv=%b br=%b g=%b exp 01/1/01",
               s_axi_bvalid, m_axi_bready, wr_grant);
    end
    step();
    m_axi_bvalid = 1'b0;
    s_axi_bready = '0;
    #1;
    checks++;
    if (wr_grant !== 2'b00 || s_axi_bvalid !== 2'b00 ||
        aw_hs_cnt - hs0 !== 1) begin
      failures++;
      $display("FAIL ww_done got g=%b aw_hs=%0d exp 00/1",
               wr_grant, aw_hs_cnt - hs0);
    end
  endtask

  task automatic test_concurrent();
    s_axi_awaddr[0]  = 64'h5000;
    s_axi_awvalid[0] = 1'b1;
    s_axi_wdata[0]   = 64'h1234;
    s_axi_wlast[0]   = 1'b1;
    s_axi_wvalid[0]  = 1'b1;
    s_axi_araddr[1]  = 64'h6000;
    s_axi_arlen[1]   = 8'd0;
    s_axi_arvalid[1] = 1'b1;
    step();
    checks++;
    if (rd_grant !== 2'b10 || wr_grant !== 2'b01) begin
      failures++;
      $display("FAIL cc_grant got rd=%b wr=%b exp 10/01",
               rd_grant, wr_grant);
    end
    checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 3'b111) begin
      failures++;
      $display("FAIL cc_fwd got %b exp 111",
               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid});
    end
    m_axi_arready = 1'b1;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    step();
    clear_inputs();
    s_axi_rready = 2'b10;
    s_axi_bready = 2'b01;
    m_axi_rdata  = 64'h7777;
    m_axi_rlast  = 1'b1;
    m_axi_rvalid = 1'b1;
    m_axi_bvalid = 1'b1;
    #1;
    checks++;
    if (s_axi_rvalid !== 2'b10 || s_axi_bvalid !== 2'b01 ||
        s_axi_rdata[1] !== 64'h7777 || m_axi_awvalid !== 1'b0 ||
        wr_grant !== 2'b01) begin
      failures++;
      $display("FAIL cc_resp got rv=%b bv=%b g=%b",
               s_axi_rvalid, s_axi_bvalid, wr_grant);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (rd_grant !== 2'b00 || wr_grant !== 2'b00) begin
      failures++;
      $display("FAIL cc_idle got rd=%b wr=%b exp 00/00",
               rd_grant, wr_grant);
    end
  endtask

  task automatic test_backpressure_reset();
    s_axi_araddr[0]  = 64'h9000;
    s_axi_arlen[0]   = 8'd3;
    s_axi_arvalid[0] = 1'b1;
    step();
    m_axi_arready = 1'b1;
    step();
    s_axi_arvalid = '0;
    m_axi_arready = 1'b0;
    s_axi_rready  = 2'b01;
    m_axi_rdata   = 64'h55;
    m_axi_rvalid  = 1'b1;
    step();
    m_axi_rdata  = 64'h66;
    s_axi_rready = 2'b00;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (m_axi_rready !== 1'b0 || s_axi_rvalid !== 2'b01 ||
          s_axi_rdata[0] !== 64'h66) begin
        failures++;
        $display("FAIL bp_hold%0d got rr=%b rv=%b d=%h exp 0/01/66",
                 c, m_axi_rready, s_axi_rvalid, s_axi_rdata[0]);
      end
      step();
    end
    rst          = 1'b1;
    s_axi_rready = 2'b11;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (m_axi_rready !== 1'b0 || s_axi_rvalid !== 2'b00 ||
        rd_grant !== 2'b00 || m_axi_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL rs_idle got rr=%b rv=%b g=%b",
               m_axi_rready, s_axi_rvalid, rd_grant);
    end
    clear_inputs();
    s_axi_arvalid = 2'b11;
    s_axi_awvalid = 2'b11;
    step();
    checks++;
    if (rd_grant !== 2'b01 || wr_grant !== 2'b01) begin
      failures++;
      $display("FAIL rs_ptr got rd=%b wr=%b exp 01/01",
               rd_grant, wr_grant);
    end
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    aw_hs_cnt = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_w_first();
    test_concurrent();
    test_backpressure_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
